dii_packet_tx: RTL and testbench

Transmitter side of the DII flit interface. It accepts one packet request per handshake: destination, source, type fields and up to MAX_PAYLOAD 16-bit payload words, presented in parallel. It serializes the request into a DII flit stream with header flits first, then payload, marking last on the final flit. Debug modules use it to emit packets into a dii_buffer or the debug ring.

---
 rtl/dii_packet_tx.sv | 162 ++++++++++++++++
 tb/tb_dii_packet_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dii_packet_tx.sv
// DII packet transmitter: turns one parallel packet request into a dest/src/header/payload flit stream.
// Optional build macro DII_PACKET_TX_BACK2BACK_EN accepts the next request in the cycle the last flit fires.
package dii_packet_tx_pkg;
    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        valid;
    } dii_flit;
endpackage

module dii_packet_tx
    import dii_packet_tx_pkg::*;
#(
    parameter  int MAX_PAYLOAD = 8,
    localparam int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [15:0]               req_dest,
    input  logic [15:0]               req_src,
    input  logic [1:0]                req_type,
    input  logic [3:0]                req_type_sub,
    input  logic [16*MAX_PAYLOAD-1:0] req_payload,
    input  logic [LEN_W-1:0]          req_payload_len,
    output dii_flit                   flit_out,
    input  logic                      flit_out_ready,
    output logic                      busy
);
    localparam int               IDX_W     = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_PAYLOAD);
    localparam dii_flit          FLIT_IDLE = '{data: 16'h0000, last: 1'b0, valid: 1'b0};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEST    = 3'd1,
        SRC     = 3'd2,
        HDR     = 3'd3,
        PAYLOAD = 3'd4
    } state_t;

    state_t                    state_r;
    logic [15:0]               dest_r;
    logic [15:0]               src_r;
    logic [1:0]                type_r;
    logic [3:0]                type_sub_r;
    logic [16*MAX_PAYLOAD-1:0] payload_r;
    logic [LEN_W-1:0]          len_r;
    logic [IDX_W-1:0]          idx_r;
    dii_flit                   flit_r;

    logic                      fire_s;
    logic                      last_fire_s;
    logic                      accept_s;
    logic [LEN_W-1:0]          len_clamped_s;
    logic [LEN_W-1:0]          last_idx_s;
    logic [LEN_W-1:0]          idx_ext_s;

    function automatic logic [15:0] hdr_word(input logic [1:0] t, input logic [3:0] s);
        return {t, s, 10'b00_0000_0000};
    endfunction

    function automatic logic [15:0] payload_word(input logic [16*MAX_PAYLOAD-1:0] p,
                                                 input logic [IDX_W-1:0]          i);
        return p[16*i +: 16];
    endfunction

    // Handshake qualifiers, length clamp and index bookkeeping.
    always_comb begin
        fire_s      = flit_r.valid && flit_out_ready;
        last_fire_s = fire_s && flit_r.last;
        if (req_payload_len > MAX_LEN) begin
            len_clamped_s = MAX_LEN;
        end else begin
            len_clamped_s = req_payload_len;
        end
        last_idx_s = len_r - LEN_W'(1);
        idx_ext_s  = LEN_W'(idx_r);
`ifdef DII_PACKET_TX_BACK2BACK_EN
        req_ready  = (state_r == IDLE) || last_fire_s;
`else
        req_ready  = (state_r == IDLE);
`endif
        accept_s   = req_valid && req_ready;
        flit_out   = flit_r;
        busy       = (state_r != IDLE);
    end

    // Packet FSM; the flit register is loaded with the next flit whenever the current one fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            flit_r     <= FLIT_IDLE;
            dest_r     <= 16'h0000;
            src_r      <= 16'h0000;
            type_r     <= 2'b00;
            type_sub_r <= 4'h0;
            payload_r  <= {(16*MAX_PAYLOAD){1'b0}};
            len_r      <= {LEN_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            // Accept has priority: it can only coincide with IDLE or a final-flit fire.
            state_r      <= DEST;
            dest_r       <= req_dest;
            src_r        <= req_src;
            type_r       <= req_type;
            type_sub_r   <= req_type_sub;
            payload_r    <= req_payload;
            len_r        <= len_clamped_s;
            idx_r        <= {IDX_W{1'b0}};
            flit_r.data  <= req_dest;
            flit_r.last  <= 1'b0;
            flit_r.valid <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    flit_r <= FLIT_IDLE;
                end
                DEST: begin
                    if (fire_s) begin
                        state_r     <= SRC;
                        flit_r.data <= src_r;
                    end
                end
                SRC: begin
                    if (fire_s) begin
                        state_r     <= HDR;
                        flit_r.data <= hdr_word(type_r, type_sub_r);
                        flit_r.last <= (len_r == {LEN_W{1'b0}});
                    end
                end
                HDR: begin
                    if (last_fire_s) begin
                        state_r <= IDLE;
                        flit_r  <= FLIT_IDLE;
                    end else if (fire_s) begin
                        state_r     <= PAYLOAD;
                        idx_r       <= {IDX_W{1'b0}};
                        flit_r.data <= payload_word(payload_r, {IDX_W{1'b0}});
                        flit_r.last <= (last_idx_s == {LEN_W{1'b0}});
                    end
                end
                PAYLOAD: begin
                    // idx stops at len-1, so the increment below never wraps.
                    if (last_fire_s) begin
                        state_r <= IDLE;
                        flit_r  <= FLIT_IDLE;
                    end else if (fire_s) begin
                        idx_r       <= idx_r + IDX_W'(1);
                        flit_r.data <= payload_word(payload_r, idx_r + IDX_W'(1));
                        flit_r.last <= ((idx_ext_s + LEN_W'(1)) == last_idx_s);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    flit_r  <= FLIT_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dii_packet_tx.sv
// Self-checking bench for dii_packet_tx: directed packets plus randomized traffic against a flit-list model.
`timescale 1ns/1ps
module tb_dii_packet_tx;
    import dii_packet_tx_pkg::*;

    localparam int MAXP    = 8;
    localparam int LEN_W   = $clog2(MAXP + 1);
    localparam int LEN_TOP = (1 << LEN_W) - 1;
`ifdef DII_PACKET_TX_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic [15:0]          req_dest;
    logic [15:0]          req_src;
    logic [1:0]           req_type;
    logic [3:0]           req_type_sub;
    logic [16*MAXP-1:0]   req_payload;
    logic [LEN_W-1:0]     req_payload_len;
    dii_flit              flit_out;
    logic                 flit_out_ready;
    logic                 busy;

    dii_packet_tx #(.MAX_PAYLOAD(MAXP)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dest        (req_dest),
        .req_src         (req_src),
        .req_type        (req_type),
        .req_type_sub    (req_type_sub),
        .req_payload     (req_payload),
        .req_payload_len (req_payload_len),
        .flit_out        (flit_out),
        .flit_out_ready  (flit_out_ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]        dest;
        logic [15:0]        src;
        logic [1:0]         typ;
        logic [3:0]         sub;
        logic [16*MAXP-1:0] pay;
        int                 len;
    } req_t;

    req_t        pend_q[$];
    logic [16:0] exp_q[$];     // {last, data} in emission order
    int          fire_cyc[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          acc_cyc;
    int          busy_cnt;
    int          ready_mode;
    int          rst_at;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk_req(input logic [15:0] d, input logic [15:0] s,
                                    input logic [1:0] t, input logic [3:0] st, input int len);
        req_t r;
        r.dest = d; r.src = s; r.typ = t; r.sub = st; r.len = len;
        for (int i = 0; i < MAXP; i++) r.pay[16*i +: 16] = 16'($urandom);
        return r;
    endfunction

    // Reference: the flit list a request must produce.
    function automatic void model_push(input req_t r);
        int n;
        n = (r.len > MAXP) ? MAXP : r.len;
        exp_q.push_back({1'b0, r.dest});
        exp_q.push_back({1'b0, r.src});
        exp_q.push_back({(n == 0), 16'(int'(r.typ) * 16384 + int'(r.sub) * 1024)});
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), r.pay[16*i +: 16]});
    endfunction

    task automatic drive_inputs(input int cyc);
        if (pend_q.size() > 0) begin
            req_valid       = 1'b1;
            req_dest        = pend_q[0].dest;
            req_src         = pend_q[0].src;
            req_type        = pend_q[0].typ;
            req_type_sub    = pend_q[0].sub;
            req_payload     = pend_q[0].pay;
            req_payload_len = LEN_W'(pend_q[0].len);
        end else begin
            req_valid       = 1'b0;
            req_dest        = 16'($urandom);
            req_src         = 16'($urandom);
            req_type        = 2'($urandom);
            req_type_sub    = 4'($urandom);
            for (int i = 0; i < MAXP; i++) req_payload[16*i +: 16] = 16'($urandom);
            req_payload_len = LEN_W'($urandom);
        end
        case (ready_mode)
            0:       flit_out_ready = 1'b1;
            1:       flit_out_ready = ((cyc % 3) == 0);
            default: flit_out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    // Runs cycles (entered and left at posedge+#1) until all pending requests are sent.
    task automatic run(input int budget);
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [16:0] held = 17'h0;
        logic [16:0] e;
        fire_cyc.delete();
        busy_cnt = 0;
        acc_cyc  = -1;
        while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            drive_inputs(cyc);
            @(negedge clk);
            check("busy_vs_valid", busy, flit_out.valid);
            check("req_ready", req_ready, !flit_out.valid || (B2B && flit_out.last && flit_out_ready));
            if (busy) busy_cnt++;
            if (stalled) check("stall_hold", {flit_out.valid, flit_out.last, flit_out.data}, {1'b1, held});
            if (rst_at >= 0 && flit_out.valid && fire_cyc.size() == rst_at) rst = 1'b1;
            if (flit_out.valid && flit_out_ready) begin
                fire_cyc.push_back(cyc);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("flit", {flit_out.last, flit_out.data}, e);
                end else begin
                    check("extra_flit", exp_q.size(), 1);
                end
            end
            stalled = flit_out.valid && !flit_out_ready;
            held    = {flit_out.last, flit_out.data};
            if (req_valid && req_ready) begin
                model_push(pend_q[0]);
                void'(pend_q.pop_front());
                if (acc_cyc < 0) acc_cyc = cyc;
            end
            if (rst) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("run_timeout", (cyc < budget), 1);
    endtask

    task automatic idle_after(input string tag);
        drive_inputs(0);
        @(negedge clk);
        check(tag, {flit_out.valid, flit_out.last, busy, req_ready}, 4'b0001);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        rst = 1'b1; ready_mode = 0; rst_at = -1;
        drive_inputs(0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", flit_out.valid, 0);
        check("rst_last", flit_out.last, 0);
        check("rst_data", flit_out.data, 16'h0000);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Header-only packet.
        pend_q.push_back(mk_req(16'h0003, 16'h0001, 2'd2, 4'd5, 0));
        run(20);
        check("len0_count", fire_cyc.size(), 3);
        check("len0_first", fire_cyc[0], acc_cyc + 1);
        check("len0_span", fire_cyc[2] - fire_cyc[0], 2);
        check("len0_busy", busy_cnt, 3);
        idle_after("len0_idle");

        // Three payload words, continuous ready.
        r = mk_req(16'h1234, 16'h0042, 2'd1, 4'd3, 3);
        r.pay[15:0] = 16'hA0A0; r.pay[31:16] = 16'hB1B1; r.pay[47:32] = 16'hC2C2;
        pend_q.push_back(r);
        run(30);
        check("len3_count", fire_cyc.size(), 6);
        check("len3_span", fire_cyc[5] - fire_cyc[0], 5);
        check("len3_busy", busy_cnt, 6);
        idle_after("len3_idle");

        // Same packet under a 1,0,0 ready pattern.
        ready_mode = 1;
        pend_q.push_back(r);
        run(60);
        check("stall_count", fire_cyc.size(), 6);
        ready_mode = 0;
        idle_after("stall_idle");

        // Over-long length is clamped to MAX_PAYLOAD.
        pend_q.push_back(mk_req(16'hBEEF, 16'h0007, 2'd3, 4'd15, (MAXP + 5 > LEN_TOP) ? LEN_TOP : MAXP + 5));
        run(40);
        check("clamp_count", fire_cyc.size(), 3 + MAXP);
        check("clamp_span", fire_cyc[2 + MAXP] - fire_cyc[0], 2 + MAXP);
        idle_after("clamp_idle");

        // Reset while the second payload flit is presented.
        rst_at = 4;
        pend_q.push_back(mk_req(16'h00AA, 16'h00BB, 2'd0, 4'd1, 3));
        run(30);
        check("rst_mid_flits", fire_cyc.size(), 5);
        @(posedge clk);
        #1;
        rst = 1'b0; rst_at = -1;
        exp_q.delete();
        idle_after("rst_mid_drop");
        idle_after("rst_mid_quiet");
        pend_q.push_back(mk_req(16'h0C0D, 16'h0E0F, 2'd2, 4'd9, 2));
        run(30);
        check("rst_next_count", fire_cyc.size(), 5);
        check("rst_next_first", fire_cyc[0], acc_cyc + 1);
        idle_after("rst_next_idle");

        // Two single-word requests presented back to back.
        pend_q.push_back(mk_req(16'h1111, 16'h2222, 2'd1, 4'd2, 1));
        pend_q.push_back(mk_req(16'h3333, 16'h4444, 2'd2, 4'd4, 1));
        run(40);
        check("b2b_count", fire_cyc.size(), 8);
        check("b2b_first_span", fire_cyc[3] - fire_cyc[0], 3);
        check("b2b_gap", fire_cyc[4] - fire_cyc[3], B2B ? 1 : 2);
        check("b2b_second_span", fire_cyc[7] - fire_cyc[4], 3);
        idle_after("b2b_idle");

        // Randomized traffic with random backpressure.
        ready_mode = 2;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 5; k++)
                pend_q.push_back(mk_req(16'($urandom), 16'($urandom), 2'($urandom), 4'($urandom),
                                        $urandom_range(0, LEN_TOP)));
            run(800);
        end
        ready_mode = 0;
        idle_after("rand_idle");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
